// File: rtl/blk_scan_gen.sv
// blk_scan_gen: walks every BLK_SIZE x BLK_SIZE block of a frame once per start and emits
// the linear block index y*COLUMNS + x in raster, interleaved-column or serpentine order.
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   i_start   one-cycle pulse that begins a scan (honoured only when idle)
//   i_abort   terminates a running scan
//   i_mode    scan mode (0 raster, 1 interleave, 2 serpentine, 3 raster), latched on start
//   i_stride  interleave step, latched on start and clamped to 1..COLUMNS
//   o_busy    high while scanning
//   o_vld     o_adr/o_x/o_y valid
//   i_rdy     downstream accepts the current address
//   o_adr     linear block index
//   o_x, o_y  block column / row
//   o_sof     first address of the frame
//   o_eof     last address of the frame
module blk_scan_gen #(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480,
   parameter int unsigned BLK_SIZE   = 32,
   parameter int unsigned COLUMNS    = IMG_WIDTH / BLK_SIZE,
   parameter int unsigned ROWS       = IMG_HEIGHT / BLK_SIZE,
   parameter int unsigned ADDR_W     = (COLUMNS * ROWS > 1) ? $clog2(COLUMNS * ROWS) : 1,
   parameter int unsigned STRIDE_W   = 4,
   localparam int unsigned XW        = $clog2(COLUMNS) + 1,
   localparam int unsigned YW        = $clog2(ROWS) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic [1:0]          i_mode,
   input  logic [STRIDE_W-1:0] i_stride,
   output logic                o_busy,
   output logic                o_vld,
   input  logic                i_rdy,
   output logic [ADDR_W-1:0]   o_adr,
   output logic [XW-1:0]       o_x,
   output logic [YW-1:0]       o_y,
   output logic                o_sof,
   output logic                o_eof
);

   typedef enum logic {StIdle, StRun} state_e;

   state_e              state_q;
   logic [1:0]          mode_q;    // normalised: 3 is stored as 0
   logic [STRIDE_W-1:0] k_q;       // clamped interleave stride
   logic [STRIDE_W-1:0] g_q;       // current interleave group
   logic [XW-1:0]       x_q;
   logic [YW-1:0]       y_q;
   logic [ADDR_W-1:0]   adr_q;
   logic                sof_q;
   logic                eof_q;

   // True when (x, y, g) is the last block visited in its row for the given mode.
   function automatic logic row_end(input logic [1:0] m, input int unsigned k,
                                    input int unsigned x, input int unsigned y,
                                    input int unsigned g);
      case (m)
         2'd1:    return (g == k - 1) && (x + k >= COLUMNS);
         2'd2:    return (y % 2 == 1) ? (x == 0) : (x == COLUMNS - 1);
         default: return x == COLUMNS - 1;
      endcase
   endfunction

   function automatic int unsigned clamp_k(input logic [STRIDE_W-1:0] s);
      int unsigned si;
      si = 32'(s);
      if (si == 0) return 1;
      if (si > COLUMNS) return COLUMNS;
      return si;
   endfunction

   int unsigned xi, yi, gi, ki, nx, ny, ng, sk;
   logic        n_eof, s_eof;
   logic [1:0]  s_mode;

   always_comb begin
      xi = 32'(x_q);
      yi = 32'(y_q);
      gi = 32'(g_q);
      ki = 32'(k_q);
      nx = xi;
      ny = yi;
      ng = gi;
      if (row_end(mode_q, ki, xi, yi, gi)) begin
         ny = yi + 1;
         ng = 0;
         // Serpentine: an odd row starts from the right-hand edge.
         nx = (mode_q == 2'd2 && yi % 2 == 0) ? COLUMNS - 1 : 0;
      end else begin
         case (mode_q)
            2'd1: begin
               if (xi + ki < COLUMNS) begin
                  nx = xi + ki;
               end else begin
                  ng = gi + 1;
                  nx = gi + 1;
               end
            end
            2'd2:    nx = (yi % 2 == 1) ? xi - 1 : xi + 1;
            default: nx = xi + 1;
         endcase
      end
      n_eof  = (ny == ROWS - 1) && row_end(mode_q, ki, nx, ny, ng);

      s_mode = (i_mode == 2'd3) ? 2'd0 : i_mode;
      sk     = clamp_k(i_stride);
      s_eof  = (ROWS == 1) && row_end(s_mode, sk, 0, 0, 0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         mode_q  <= '0;
         k_q     <= '0;
         g_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         adr_q   <= '0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (i_start) begin
                  state_q <= StRun;
                  mode_q  <= s_mode;
                  k_q     <= STRIDE_W'(sk);
                  g_q     <= '0;
                  x_q     <= '0;
                  y_q     <= '0;
                  adr_q   <= '0;
                  sof_q   <= 1'b1;
                  eof_q   <= s_eof;
               end
            end
            StRun: begin
               // Abort, or the final handshake, both return to an all-zero idle.
               if (i_abort || (i_rdy && eof_q)) begin
                  state_q <= StIdle;
                  g_q     <= '0;
                  x_q     <= '0;
                  y_q     <= '0;
                  adr_q   <= '0;
                  sof_q   <= 1'b0;
                  eof_q   <= 1'b0;
               end else if (i_rdy) begin
                  g_q   <= STRIDE_W'(ng);
                  x_q   <= XW'(nx);
                  y_q   <= YW'(ny);
                  adr_q <= ADDR_W'(ny * COLUMNS + nx);
                  sof_q <= 1'b0;
                  eof_q <= n_eof;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign o_busy = (state_q == StRun);
   assign o_vld  = (state_q == StRun);
   assign o_adr  = adr_q;
   assign o_x    = x_q;
   assign o_y    = y_q;
   assign o_sof  = sof_q;
   assign o_eof  = eof_q;

endmodule

// File: tb/tb_blk_scan_gen.sv
module tb_blk_scan_gen;

   localparam int unsigned C  = 10;
   localparam int unsigned R  = 3;
   localparam int unsigned SW = 4;
   localparam int unsigned AW = 5;
   localparam int unsigned XW = 5;
   localparam int unsigned YW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_start = 1'b0;
   logic          i_abort = 1'b0;
   logic [1:0]    i_mode = '0;
   logic [SW-1:0] i_stride = '0;
   logic          i_rdy = 1'b1;
   logic          o_busy, o_vld, o_sof, o_eof;
   logic [AW-1:0] o_adr;
   logic [XW-1:0] o_x;
   logic [YW-1:0] o_y;

   blk_scan_gen #(
      .IMG_WIDTH (320),
      .IMG_HEIGHT(96),
      .BLK_SIZE  (32),
      .STRIDE_W  (SW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_start (i_start),
      .i_abort (i_abort),
      .i_mode  (i_mode),
      .i_stride(i_stride),
      .o_busy  (o_busy),
      .o_vld   (o_vld),
      .i_rdy   (i_rdy),
      .o_adr   (o_adr),
      .o_x     (o_x),
      .o_y     (o_y),
      .o_sof   (o_sof),
      .o_eof   (o_eof)
   );

   always #5 clk = ~clk;

   typedef struct {
      int adr;
      int x;
      int y;
      int sof;
      int eof;
   } beat_t;

   beat_t exp_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    hs_cnt = 0;
   bit    rdy_rand = 1'b0;
   bit    chk_idle = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference order built directly from the scan rules.
   function automatic void push_frame(input int mode, input int stride);
      int    m, k, n;
      int    xs[$];
      beat_t b;
      m = (mode == 3) ? 0 : mode;
      k = (stride == 0) ? 1 : ((stride > int'(C)) ? int'(C) : stride);
      n = 0;
      for (int y = 0; y < int'(R); y++) begin
         xs.delete();
         if (m == 1) begin
            for (int g = 0; g < k; g++)
               for (int x = g; x < int'(C); x += k) xs.push_back(x);
         end else begin
            for (int x = 0; x < int'(C); x++)
               xs.push_back((m == 2 && y % 2 == 1) ? int'(C) - 1 - x : x);
         end
         foreach (xs[i]) begin
            b.adr = y * int'(C) + xs[i];
            b.x   = xs[i];
            b.y   = y;
            b.sof = (n == 0) ? 1 : 0;
            b.eof = (n == int'(C * R) - 1) ? 1 : 0;
            exp_q.push_back(b);
            n++;
         end
      end
   endfunction

   // Random or constant ready, changed just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         i_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: scoreboard pop on handshake, stall stability, idle after eof.
   initial begin
      bit    prev_stall;
      beat_t held, e;
      prev_stall = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_idle) begin
            check("eof_next_vld", int'(o_vld), 0);
            check("eof_next_busy", int'(o_busy), 0);
            check("eof_next_adr", int'(o_adr), 0);
            chk_idle = 1'b0;
         end
         if (rst || i_abort) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_vld", int'(o_vld), 1);
               check("stall_adr", int'(o_adr), held.adr);
               check("stall_x", int'(o_x), held.x);
               check("stall_y", int'(o_y), held.y);
               check("stall_sof", int'(o_sof), held.sof);
               check("stall_eof", int'(o_eof), held.eof);
            end
            if (o_vld && i_rdy) begin
               hs_cnt++;
               if (exp_q.size() == 0) begin
                  check("unexpected_beat_adr", int'(o_adr), -1);
               end else begin
                  e = exp_q.pop_front();
                  check("beat_adr", int'(o_adr), e.adr);
                  check("beat_x", int'(o_x), e.x);
                  check("beat_y", int'(o_y), e.y);
                  check("beat_sof", int'(o_sof), e.sof);
                  check("beat_eof", int'(o_eof), e.eof);
                  if (e.eof != 0) chk_idle = 1'b1;
               end
            end
            prev_stall = o_vld && !i_rdy;
            held.adr = int'(o_adr);
            held.x   = int'(o_x);
            held.y   = int'(o_y);
            held.sof = int'(o_sof);
            held.eof = int'(o_eof);
         end
      end
   end

   // All tasks start and end just after a rising edge.
   task automatic start_frame(input int mode, input int stride);
      i_mode   = 2'(mode);
      i_stride = SW'(stride);
      i_start  = 1'b1;
      push_frame(mode, stride);
      hs_cnt = 0;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      check("start_vld", int'(o_vld), 1);
      check("start_sof", int'(o_sof), 1);
      check("start_busy", int'(o_busy), 1);
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 2000; i++) begin
         if (exp_q.size() == 0 && !o_busy) break;
         @(posedge clk);
         #1;
      end
      check({name, "_done"}, int'(exp_q.size() == 0 && !o_busy), 1);
      check({name, "_beats"}, hs_cnt, int'(C * R));
   endtask

   task automatic check_zero(input string name);
      check({name, "_vld"}, int'(o_vld), 0);
      check({name, "_busy"}, int'(o_busy), 0);
      check({name, "_adr"}, int'(o_adr), 0);
      check({name, "_x"}, int'(o_x), 0);
      check({name, "_y"}, int'(o_y), 0);
      check({name, "_sof"}, int'(o_sof), 0);
      check({name, "_eof"}, int'(o_eof), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      start_frame(0, 0);  wait_done("raster");
      start_frame(1, 4);  wait_done("ilv_k4");
      start_frame(1, 0);  wait_done("ilv_k0");
      start_frame(1, 15); wait_done("ilv_k15");
      start_frame(2, 0);  wait_done("serp");
      start_frame(3, 7);  wait_done("mode3");

      // Backpressure with an ignored start pulse mid-run.
      rdy_rand = 1'b1;
      start_frame(1, 3);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      i_mode  = 2'd2;
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      wait_done("bp");
      rdy_rand = 1'b0;

      // Abort while idle does nothing.
      i_abort = 1'b1;
      @(posedge clk);
      #1;
      i_abort = 1'b0;
      check("idle_abort_busy", int'(o_busy), 0);
      check("idle_abort_vld", int'(o_vld), 0);

      // Abort after beat 5, then a clean restart.
      start_frame(0, 0);
      for (int i = 0; i < 200 && hs_cnt < 5; i++) begin
         @(posedge clk);
         #1;
      end
      check("abort_reach5", int'(hs_cnt >= 5), 1);
      i_abort = 1'b1;
      @(posedge clk);
      #1;
      i_abort = 1'b0;
      exp_q.delete();
      check("abort_vld", int'(o_vld), 0);
      check("abort_busy", int'(o_busy), 0);
      check("abort_eof", int'(o_eof), 0);
      start_frame(2, 0);
      wait_done("after_abort");

      // Start and abort together in idle: start wins.
      i_abort = 1'b1;
      start_frame(1, 4);
      i_abort = 1'b0;
      wait_done("start_abort");

      // Reset mid-frame.
      start_frame(1, 4);
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      check_zero("mid_reset");
      start_frame(0, 0);
      wait_done("after_reset");

      // Random modes, strides and ready patterns.
      repeat (10) begin
         rdy_rand = 1'($urandom_range(0, 1));
         start_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
         wait_done("random");
      end
      rdy_rand = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/blk_scan_gen.md
Name: blk_scan_gen

Overview:
- Parametrised successor to the frame block-address generator.
- Walks every BLK_SIZE x BLK_SIZE block of a frame once per start and emits the linear block index y*COLUMNS + x.
- Three scan modes are selectable at run time: raster, interleaved column groups with a run-time stride, and serpentine.
- Uses a valid/ready output handshake so downstream stalls are tolerated. Sits between the frame controller and the block-fetch DMA.

Parameters:
- IMG_WIDTH, 640, image width in pixels.
- IMG_HEIGHT, 480, image height in pixels.
- BLK_SIZE, 32, block edge in pixels.
- COLUMNS, IMG_WIDTH/BLK_SIZE, blocks per row; must be >= 1.
- ROWS, IMG_HEIGHT/BLK_SIZE, block rows; must be >= 1.
- ADDR_W, max(1,$clog2(COLUMNS*ROWS)), address width.
- STRIDE_W, 4, width of the run-time interleave stride.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- i_start  in  1  one-cycle pulse that begins a frame scan; honoured only in IDLE.
- i_abort  in  1  terminates the scan; the block returns to IDLE next cycle.
- i_mode  in  2  scan mode: 0 raster, 1 interleave, 2 serpentine, 3 treated as raster. Latched on start.
- i_stride  in  STRIDE_W  interleave step K. Latched on start.
- o_busy  out  1  high in RUN.
- o_vld  out  1  o_adr, o_x and o_y are valid.
- i_rdy  in  1  downstream accepts the current address.
- o_adr  out  ADDR_W  linear block index.
- o_x  out  $clog2(COLUMNS)+1  block column.
- o_y  out  $clog2(ROWS)+1  block row.
- o_sof  out  1  high with the first address of the frame.
- o_eof  out  1  high with the last address of the frame.

Behaviour:
- Reset:
  - rst sampled high clears every output to 0 and moves the FSM to IDLE.
  - Mid-scan reset drops o_vld the next cycle; no eof is generated.
- FSM states and transitions:
  - IDLE to RUN on i_start.
  - RUN to IDLE on handshake (o_vld & i_rdy) with o_eof=1.
  - RUN to IDLE on i_abort.
- Start latency: start sampled in cycle N gives o_vld=1 with the first address and o_sof=1 in cycle N+1.
- i_start while RUN is ignored.
- Handshake:
  - o_adr, o_x, o_y, o_sof and o_eof hold stable while o_vld & !i_rdy.
  - The next address is presented in the cycle after each handshake.
  - o_vld stays high continuously between start and the final handshake, so throughput is one address per cycle under i_rdy=1.
- Abort:
  - i_abort has priority over a handshake in the same cycle.
  - Next cycle: o_vld=0, o_busy=0, no eof.
  - i_abort in IDLE has no effect.
  - i_start and i_abort in the same IDLE cycle: start wins.
- Stride clamp, applied at latch: K = (i_stride==0) ? 1 : min(i_stride, COLUMNS).
- Mode 0 (raster): x runs 0..COLUMNS-1, then y increments.
- Mode 1 (interleave):
  - Within each row, visit x = g, g+K, g+2K, ... while x < COLUMNS, for g = 0..K-1, then advance to the next row.
  - Groups may be unequal when COLUMNS % K != 0.
  - K==1 or K==COLUMNS yields raster order.
- Mode 2 (serpentine): even rows run x = 0..COLUMNS-1, odd rows run x = COLUMNS-1..0.
- Arithmetic:
  - o_adr = y*COLUMNS + x, registered together with x and y. No combinational path from i_rdy to o_adr.
  - COLUMNS*ROWS-1 must fit in ADDR_W.
- Count: exactly COLUMNS*ROWS handshakes per frame; each index appears exactly once.
- Degenerate frame: a 1x1 frame gives a single beat with o_sof=o_eof=1.
- End of frame: after the final handshake, o_vld and o_busy are 0 the next cycle and outputs return to 0. A new start is accepted the cycle after the final handshake.

Test Plan:
- Raster: COLUMNS=10, ROWS=3, mode 0, i_rdy=1 -> 30 beats, o_adr 0..29, o_sof on beat 0, o_eof on beat 29; o_vld=0 on the following cycle.
- Interleave: COLUMNS=10, ROWS=3, mode 1, stride 4 -> row 0 x order 0,4,8,1,5,9,2,6,3,7; row 1 addresses 10,14,18,11,...,17; 30 unique beats.
- Stride clamp: mode 1 with stride 0, and separately with stride 15 (COLUMNS=10) -> both give raster order 0..29.
- Serpentine: COLUMNS=10, ROWS=3, mode 2 -> 0..9, 19..10, 20..29.
- Backpressure: random i_rdy at 50% -> outputs stable while stalled, sequence identical to the i_rdy=1 run; a start pulse mid-run is ignored.
- Abort and reset:
  - i_abort after beat 5 -> o_vld=0 next cycle, no eof; a new start restarts at o_adr 0 with o_sof.
  - rst mid-frame -> all outputs 0 next cycle.
